// File: rtl/score_pkg.sv
// Shared constants, types and helpers for the brick-scoring engine.
// Holds the per-level point table, the combo width, the BCD converter states and saturating addition.
package score_pkg;

   localparam int LEVEL_CNT = 16;
   localparam int COMBO_W   = 3;

   // Index 0 is the top (most valuable) level; every level past the table scores 1.
   localparam logic [3:0] LEVEL_PTS [LEVEL_CNT] = '{
      4'd10, 4'd8, 4'd5, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1,
      4'd1,  4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } bcd_state_e;

   function automatic logic [3:0] level_pts(input int lvl);
      logic [3:0] pts;
      pts = 4'd1;
      for (int i = 0; i < LEVEL_CNT; i++)
         if (lvl == i) pts = LEVEL_PTS[i];
      return pts;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] lim);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, lim}) ? lim : sum[31:0];
   endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// start_i aborts any conversion in flight and forces a fresh one from IDLE.
module bcd_seq_conv
   import score_pkg::*;
#(
   parameter int SCORE_W    = 14,
   parameter int BCD_DIGITS = 5
) (
   input  logic                    clk_i,
   input  logic                    srst_i,
   input  logic                    start_i,
   input  logic [SCORE_W-1:0]      value_i,
   output logic                    busy_o,
   output logic                    valid_o,
   output logic [4*BCD_DIGITS-1:0] bcd_o
);

   localparam int CNT_W = $clog2(SCORE_W + 1);

   bcd_state_e                state_q;
   logic [SCORE_W-1:0]        latched_q;
   logic [SCORE_W-1:0]        bin_q;
   logic [4*BCD_DIGITS-1:0]   shift_q;
   logic [4*BCD_DIGITS-1:0]   adj_d;
   logic [4*BCD_DIGITS-1:0]   shift_d;
   logic [4*BCD_DIGITS-1:0]   bcd_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      valid_q;

   genvar gi;
   generate
      for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_dig
         logic [3:0] dig;
         assign dig = shift_q[4*gi +: 4];
         assign adj_d[4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
      end
   endgenerate

   assign shift_d = {adj_d[4*BCD_DIGITS-2:0], bin_q[SCORE_W-1]};

   // Entering LOAD captures the operand; the LOAD cycle itself already runs the first iteration.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q   <= IDLE;
         latched_q <= '0;
         bin_q     <= '0;
         shift_q   <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b1;
      end else if (start_i) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (value_i != latched_q || !valid_q) begin
                  state_q   <= LOAD;
                  latched_q <= value_i;
                  bin_q     <= value_i;
                  shift_q   <= '0;
                  cnt_q     <= '0;
                  valid_q   <= 1'b0;
               end
            end
            LOAD, SHIFT: begin
               bin_q   <= bin_q << 1;
               shift_q <= shift_d;
               cnt_q   <= cnt_q + 1'b1;
               state_q <= (cnt_q == CNT_W'(SCORE_W - 1)) ? DONE : SHIFT;
            end
            DONE: begin
               bcd_q <= shift_q;
               if (value_i == latched_q) begin
                  valid_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  state_q   <= LOAD;
                  latched_q <= value_i;
                  bin_q     <= value_i;
                  shift_q   <= '0;
                  cnt_q     <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign valid_o = valid_q;
   assign bcd_o   = bcd_q;

endmodule

// File: rtl/score_accumulator.sv
// Brick-scoring engine: weighted awards, combo multiplier, saturating score, BCD display feed.
// Define SCORE_HIGH_SCORE_EN to build the high-score register; otherwise oHighScore is 0.
module score_accumulator
   import score_pkg::*;
#(
   parameter int NUM_ROWS       = 10,
   parameter int ROWS_PER_LEVEL = 2,
   parameter int SCORE_W        = 14,
   parameter int BCD_DIGITS     = 5,
   parameter int MAX_MULT       = 4
) (
   input  logic                    iCLK,
   input  logic                    iRST,
   input  logic                    iNewGame,
   input  logic                    iCollision,
   input  logic                    iBall,
   input  logic [NUM_ROWS-1:0]     iRowBricks,
   input  logic                    iPaddleHit,
   output logic [SCORE_W-1:0]      oScore,
   output logic [4*BCD_DIGITS-1:0] oScoreBCD,
   output logic                    oBcdValid,
   output logic [COMBO_W-1:0]      oCombo,
   output logic [SCORE_W-1:0]      oHighScore
);

   localparam logic [31:0] SCORE_MAX = {{(32-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

   logic               coll_q;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [COMBO_W-1:0] combo_q, combo_d;
   logic [3:0]         row_pts [NUM_ROWS];
   logic [3:0]         pts;
   logic [31:0]        award;
   logic               take;
   logic               conv_busy, conv_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         assign row_pts[gi] = level_pts(gi / ROWS_PER_LEVEL);
      end
   endgenerate

   // Walking downwards lets the lowest-index (highest-value) set row win.
   always_comb begin
      pts = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--)
         if (iRowBricks[r]) pts = row_pts[r];
   end

   assign take  = iCollision && !coll_q && iBall && (|iRowBricks);
   assign award = 32'(pts) * 32'(combo_q);

   always_comb begin
      score_d = score_q;
      combo_d = combo_q;
      if (iNewGame) begin
         score_d = '0;
         combo_d = COMBO_W'(1);
      end else begin
         if (take) score_d = SCORE_W'(sat_add(32'(score_q), award, SCORE_MAX));
         if (iPaddleHit)
            combo_d = COMBO_W'(1);
         else if (take && combo_q < COMBO_W'(MAX_MULT))
            combo_d = combo_q + 1'b1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         coll_q  <= 1'b0;
         score_q <= '0;
         combo_q <= COMBO_W'(1);
      end else begin
         coll_q  <= iCollision;
         score_q <= score_d;
         combo_q <= combo_d;
      end
   end

   bcd_seq_conv #(
      .SCORE_W    (SCORE_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bcd (
      .clk_i   (iCLK),
      .srst_i  (iRST),
      .start_i (iNewGame),
      .value_i (score_q),
      .busy_o  (conv_busy),
      .valid_o (conv_valid),
      .bcd_o   (oScoreBCD)
   );

`ifdef SCORE_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q;
   always_ff @(posedge iCLK) begin
      if (iRST)                 high_q <= '0;
      else if (score_q > high_q) high_q <= score_q;
   end
   assign oHighScore = high_q;
`else
   assign oHighScore = '0;
`endif

   assign oScore    = score_q;
   assign oCombo    = combo_q;
   assign oBcdValid = conv_valid && !conv_busy;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed plus random checks of score_accumulator against a behavioural scoring model.
// The model works from the scoring rules in plain integer arithmetic and checks every cycle.
module tb_score_accumulator;

   localparam int NUM_ROWS = 10;
   localparam int SMAX     = 16383;

   logic        clk = 1'b0;
   logic        iRST, iNewGame, iCollision, iBall, iPaddleHit;
   logic [9:0]  iRowBricks;
   logic [13:0] oScore, oHighScore;
   logic [19:0] oScoreBCD;
   logic        oBcdValid;
   logic [2:0]  oCombo;

   int total = 0;
   int bad   = 0;
   int m_score, m_combo, m_high;
   bit m_prev;
   int pts_tab [5] = '{10, 8, 5, 3, 1};

   always #5 clk = ~clk;

   score_accumulator dut (
      .iCLK(clk), .iRST(iRST), .iNewGame(iNewGame), .iCollision(iCollision),
      .iBall(iBall), .iRowBricks(iRowBricks), .iPaddleHit(iPaddleHit),
      .oScore(oScore), .oScoreBCD(oScoreBCD), .oBcdValid(oBcdValid),
      .oCombo(oCombo), .oHighScore(oHighScore)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int t;
      r = '0;
      t = v;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Apply one clock with the current inputs; update the model, then compare at the falling edge.
   task automatic cycle();
      int  pts, nhigh;
      bit  ev, take;
      if (iRST) begin
         m_score = 0; m_combo = 1; m_prev = 0; m_high = 0;
      end else begin
         nhigh  = (m_score > m_high) ? m_score : m_high;
         ev     = iCollision && !m_prev;
         m_prev = iCollision;
         pts = 0;
         for (int r = NUM_ROWS - 1; r >= 0; r--)
            if (iRowBricks[r]) pts = (r / 2 < 5) ? pts_tab[r / 2] : 1;
         take = ev && iBall && (pts != 0);
         if (iNewGame) begin
            m_score = 0; m_combo = 1;
         end else begin
            if (take) m_score = (m_score + pts * m_combo > SMAX) ? SMAX : m_score + pts * m_combo;
            if (iPaddleHit) m_combo = 1;
            else if (take && m_combo < 4) m_combo = m_combo + 1;
         end
`ifdef SCORE_HIGH_SCORE_EN
         m_high = nhigh;
`else
         m_high = 0 * nhigh;
`endif
      end
      @(posedge clk);
      @(negedge clk);
      chk("score", 32'(oScore), 32'(m_score));
      chk("combo", 32'(oCombo), 32'(m_combo));
      chk("high",  32'(oHighScore), 32'(m_high));
   endtask

   task automatic hit(input logic [9:0] rows, input logic ball);
      iCollision = 1'b1; iBall = ball; iRowBricks = rows;
      cycle();
      iCollision = 1'b0; iRowBricks = '0;
      cycle();
   endtask

   task automatic wait_bcd(output int n);
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         cycle();
         n = i;
         if (oBcdValid) break;
      end
      chk("bcd_valid", 32'(oBcdValid), 32'd1);
      chk("bcd", 32'(oScoreBCD), 32'(to_bcd(m_score)));
   endtask

   initial begin
      int n;
      iRST = 1'b1; iNewGame = 0; iCollision = 0; iBall = 0; iRowBricks = '0; iPaddleHit = 0;
      @(negedge clk);
      cycle();
      cycle();
      iRST = 1'b0;
      chk("rst_bcd",   32'(oScoreBCD), 32'd0);
      chk("rst_valid", 32'(oBcdValid), 32'd1);

      // First award: bottom row, combo 1; conversion latency measured from the score edge.
      iCollision = 1'b1; iBall = 1'b1; iRowBricks = 10'b10_0000_0000;
      cycle();
      chk("first_score", 32'(oScore), 32'd1);
      chk("first_combo", 32'(oCombo), 32'd2);
      iCollision = 1'b0; iRowBricks = '0;
      wait_bcd(n);
      chk("latency", 32'(n), 32'd16);
      chk("first_bcd", 32'(oScoreBCD), 32'h00001);

      hit(10'b00_0000_0001, 1'b1);
      chk("top_row", 32'(oScore), 32'd21);
      chk("combo3",  32'(oCombo), 32'd3);
      hit(10'b00_0000_0001, 1'b1);
      hit(10'b00_0000_0001, 1'b1);
      chk("combo_pin", 32'(oCombo), 32'd4);
      hit(10'b00_0000_0101, 1'b1);
      chk("multi_row", 32'(oScore), 32'd131);

      // Held collision level yields exactly one event.
      iCollision = 1'b1; iBall = 1'b1; iRowBricks = 10'b00_0000_0001;
      repeat (5) cycle();
      iCollision = 1'b0; iRowBricks = '0;
      cycle();
      chk("held", 32'(oScore), 32'd171);
      hit(10'b00_0000_0001, 1'b0);
      chk("no_ball", 32'(oScore), 32'd171);

      iCollision = 1'b1; iBall = 1'b1; iRowBricks = 10'b10_0000_0000; iPaddleHit = 1'b1;
      cycle();
      iCollision = 1'b0; iRowBricks = '0; iPaddleHit = 1'b0;
      chk("paddle_score", 32'(oScore), 32'd175);
      chk("paddle_combo", 32'(oCombo), 32'd1);

      // Climb to 16380 at combo 4, then saturate.
      iNewGame = 1'b1; cycle(); iNewGame = 1'b0;
      repeat (3) hit(10'b00_0000_0001, 1'b1);
      repeat (408) hit(10'b00_0000_0001, 1'b1);
      chk("preload", 32'(oScore), 32'd16380);
      hit(10'b00_0000_0001, 1'b1);
      chk("saturate", 32'(oScore), 32'd16383);
      wait_bcd(n);
      chk("sat_bcd", 32'(oScoreBCD), 32'h16383);

      // New game lands mid-conversion.
      iNewGame = 1'b1; cycle(); iNewGame = 1'b0;
      hit(10'b00_0000_0010, 1'b1);
      repeat (5) cycle();
      iNewGame = 1'b1; cycle(); iNewGame = 1'b0;
      chk("ng_score", 32'(oScore), 32'd0);
      wait_bcd(n);
      chk("ng_bcd", 32'(oScoreBCD), 32'd0);
`ifdef SCORE_HIGH_SCORE_EN
      chk("ng_high", 32'(oHighScore), 32'd16383);
`else
      chk("ng_high", 32'(oHighScore), 32'd0);
`endif

      for (int i = 0; i < 600; i++) begin
         iRST       = ($urandom_range(0, 199) == 0);
         iNewGame   = ($urandom_range(0, 49) == 0);
         iCollision = $urandom_range(0, 1);
         iBall      = ($urandom_range(0, 3) != 0);
         iPaddleHit = ($urandom_range(0, 9) == 0);
         iRowBricks = 10'($urandom) & 10'($urandom);
         cycle();
         if (i % 100 == 99) begin
            iRST = 0; iNewGame = 0; iCollision = 0; iPaddleHit = 0; iRowBricks = '0;
            wait_bcd(n);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
- Parametrised, fully synchronous brick-scoring engine.
- Converts brick-collision events into weighted points, applies a consecutive-hit combo multiplier and saturates the running score.
- Feeds the 7-segment path through an internal sequential BCD converter.
- Sits between the collision/brick-map logic and the score display; Collision is edge-detected on iCLK and never used as a clock.

Parameters:
NUM_ROWS, 10, number of brick rows; bit 0 of iRowBricks is the top (highest-value) row
ROWS_PER_LEVEL, 2, adjacent rows sharing one point value
SCORE_W, 14, binary score width (max 16383)
BCD_DIGITS, 5, decimal digits on oScoreBCD
MAX_MULT, 4, combo multiplier ceiling (>=1)

Ports:
iCLK  in  1  system clock
iRST  in  1  synchronous active-high reset
iNewGame  in  1  one-cycle pulse: clear score/combo, keep high score
iCollision  in  1  collision flag, level; rising edge = one event
iBall  in  1  collision is ball-vs-brick (gates scoring)
iRowBricks  in  NUM_ROWS  rows hit at this collision
iPaddleHit  in  1  ball touched paddle; clears combo
oScore  out  SCORE_W  binary running score
oScoreBCD  out  4*BCD_DIGITS  BCD of last converted score
oBcdValid  out  1  oScoreBCD matches oScore
oCombo  out  3  current multiplier (1..MAX_MULT)
oHighScore  out  SCORE_W  best score (HIGH_SCORE_EN only, else 0)

Behaviour:
- Reset (iRST=1 at an iCLK edge): oScore=0, oCombo=1, oScoreBCD=0, oBcdValid=1, oHighScore=0, edge register=0, converter IDLE. Reset wins over every other input in the same cycle, including mid-conversion.
- Event: the iCLK edge where iCollision=1 and the prior sample=0. Repeated high samples produce no further awards.
- Award is taken only if iBall=1 and |iRowBricks != 0.
- Level of row r = r / ROWS_PER_LEVEL.
- Points come from the package table LEVEL_PTS = {10,8,5,3,1,1,...}, indexed by level with index 0 = top.
- With several rows set, only the lowest-index set row scores.
- Award = points * oCombo, computed before the combo increments.
- oScore updates on the event edge itself (1-cycle latency from sampled input).
- Sum is saturating: if oScore + award > 2^SCORE_W-1, the result is 2^SCORE_W-1.
- Combo: after an awarded event, oCombo = min(oCombo+1, MAX_MULT).
- iPaddleHit=1 sets oCombo=1. If an award and iPaddleHit coincide, the award uses the old combo and oCombo ends at 1.
- iNewGame: oScore=0, oCombo=1, conversion restarts. Takes priority over an award in the same cycle.
- BCD converter states:
  - IDLE: goes to LOAD when oScore differs from the last converted value.
  - LOAD: latches oScore, clears the shift registers, deasserts oBcdValid.
  - SHIFT: SCORE_W double-dabble iterations, one per cycle.
  - DONE: updates oScoreBCD; asserts oBcdValid only if oScore still equals the latched value, otherwise goes straight back to LOAD.
- Conversion latency is SCORE_W+2 cycles from the oScore change to oBcdValid=1.
- oScoreBCD holds its old value throughout conversion (no glitching).
- Digits beyond the range of SCORE_W read 0.

Optional Feature:
SCORE_HIGH_SCORE_EN
- Defined: oHighScore tracks max(oHighScore, oScore) every cycle. Cleared only by iRST; it survives iNewGame.
- Undefined: no register is built and oHighScore is tied to 0.

Decomposition:
- Package score_pkg holds:
  - LEVEL_PTS constant array;
  - combo width constant;
  - BCD converter state enum (IDLE, LOAD, SHIFT, DONE);
  - saturating-add function.
- Sub-module bcd_seq_conv (parametrised by SCORE_W and BCD_DIGITS) implements the converter FSM with a start/busy/valid interface. The top block instantiates it once.

Test Plan:
- Reset, then iCollision rises with iBall=1, iRowBricks=10'b10_0000_0000 -> oScore=1, oCombo=2; oBcdValid=1 and oScoreBCD=0x00001 after 16 cycles.
- Next event with iRowBricks=10'b00_0000_0001 -> award 10*2 -> oScore=21, oCombo=3; further events keep oCombo pinned at 4.
- iRowBricks=10'b00_0000_0101 in one event -> only row 0 scores. Hold iCollision high for 5 cycles -> exactly one award. iBall=0 -> no award, combo unchanged.
- Preload near max (oScore=16380, combo 4), row 0 hit -> oScore=16383 (saturated); oScoreBCD=0x16383 once valid.
- Award and iPaddleHit in the same cycle -> award at old combo, oCombo=1.
- iNewGame during SHIFT -> oScore=0, conversion restarts, final oScoreBCD=0; oHighScore retains its prior max with SCORE_HIGH_SCORE_EN defined and is 0 without it.
